adc_pattern_checker: RTL and testbench

//  Parametrised multi-channel ADC test-pattern checker for SNAP2 FMC ADC bring-up. It supersedes the single-mode ramp error counter.

---
 rtl/adc_pattern_checker.sv | 156 +++++++++++++++
 tb/tb_adc_pattern_checker.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_checker.sv
// Multi-channel ADC test-pattern checker: ramp / fixed / toggle word checks with
// saturating per-channel good/bad word counters, sticky error flags and first-error index.
module adc_pattern_checker #(
  parameter int NCH  = 4,
  parameter int SPW  = 8,
  parameter int SW   = 10,
  parameter int CNTW = 48
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [1:0]            mode,
  input  logic [SW-1:0]         pattern,
  input  logic                  din_valid,
  input  logic [NCH*SPW*SW-1:0] din,
  output logic [NCH-1:0]        locked,
  output logic [NCH-1:0]        err_flag,
  output logic [NCH*CNTW-1:0]   ok_cnt,
  output logic [NCH*CNTW-1:0]   err_cnt,
  output logic [NCH*CNTW-1:0]   first_err_idx
);

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  localparam int         WORD_W      = SPW * SW;

  typedef enum logic [1:0] {IDLE, LOCK, CHECK} state_t;

  logic [1:0] mode_q;
  logic       active;
  logic       relock;

  // A mode change is detected against last cycle's mode, so any pattern switch forces a re-seed.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mode_q <= MODE_RAMP;
    else            mode_q <= mode;
  end

  assign active = en && (mode != MODE_RSVD);
  assign relock = clr || (mode != mode_q);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pred;
    logic [SW-1:0]     last_q;
    logic              phase;
    logic [SW-1:0]     tgl_val;
    logic [SPW-1:0]    cmp;
    logic              seed_phase;
    state_t            state;
    logic              locked_r;
    logic              s1_valid;
    logic [SPW-1:0]    s1_cmp;
    logic [CNTW-1:0]   ok_r, err_r, first_r;
    logic              flag_r;

    assign word       = din[c*WORD_W +: WORD_W];
    // Ramp predecessor of sample k is sample k-1; sample 0 follows the previous word's last sample.
    assign pred       = {word[WORD_W-SW-1:0], last_q};
    assign tgl_val    = phase ? ~pattern : pattern;
    assign seed_phase = (word[SW-1:0] == pattern);

    // NOTE: cmp gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
      cmp = '0;
      for (int k = 0; k < SPW; k++) begin
        case (mode)
          MODE_RAMP:   cmp[k] = (word[k*SW +: SW] == SW'(pred[k*SW +: SW] + 1'b1));
          MODE_FIXED:  cmp[k] = (word[k*SW +: SW] == pattern);
          MODE_TOGGLE: cmp[k] = (word[k*SW +: SW] == tgl_val);
          default:     cmp[k] = 1'b0;
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state    <= IDLE;
        locked_r <= 1'b0;
        last_q   <= '0;
        phase    <= 1'b0;
        s1_valid <= 1'b0;
        s1_cmp   <= '0;
      end else begin
        s1_valid <= 1'b0;
        if (!active) begin
          state    <= IDLE;
          locked_r <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              state    <= LOCK;
              locked_r <= 1'b0;
            end
            LOCK, CHECK: begin
              if (state == LOCK || relock) begin
                // Seed word: establishes the expectation and is never counted.
                if (din_valid) begin
                  state    <= CHECK;
                  locked_r <= 1'b1;
                  last_q   <= word[WORD_W-1 -: SW];
                  phase    <= seed_phase;
                end else begin
                  state    <= LOCK;
                  locked_r <= 1'b0;
                end
              end else if (din_valid) begin
                s1_valid <= 1'b1;
                s1_cmp   <= cmp;
                last_q   <= word[WORD_W-1 -: SW];
                phase    <= ~phase;
              end
            end
            default: begin
              state    <= IDLE;
              locked_r <= 1'b0;
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        ok_r    <= '0;
        err_r   <= '0;
        first_r <= '0;
        flag_r  <= 1'b0;
      end else if (clr) begin
        ok_r    <= '0;
        err_r   <= '0;
        first_r <= '0;
        flag_r  <= 1'b0;
      end else if (s1_valid) begin
        if (&s1_cmp) begin
          if (ok_r != '1) ok_r <= ok_r + 1'b1;
        end else begin
          if (err_r != '1) err_r <= err_r + 1'b1;
          if (!flag_r) first_r <= ok_r + err_r;
          flag_r <= 1'b1;
        end
      end
    end

    assign locked[c]                     = locked_r;
    assign err_flag[c]                   = flag_r;
    assign ok_cnt[c*CNTW +: CNTW]        = ok_r;
    assign err_cnt[c*CNTW +: CNTW]       = err_r;
    assign first_err_idx[c*CNTW +: CNTW] = first_r;
  end

endmodule

// File: tb/tb_adc_pattern_checker.sv
// Scoreboard bench for adc_pattern_checker: a word-level reference model pushes expected
// outputs per driven cycle; they are popped and compared once the DUT pipeline has produced them.
module tb_adc_pattern_checker;

  localparam int NCH  = 4;
  localparam int SPW  = 8;
  localparam int SW   = 10;
  localparam int CNTW = 48;
  localparam int WW   = NCH * SPW * SW;
  localparam int CW   = NCH * CNTW;
  localparam longint MAXC = (longint'(1) << CNTW) - 1;

  logic             clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [SW-1:0]    pattern = '0;
  logic             din_valid = 1'b0;
  logic [WW-1:0]    din = '0;
  logic [NCH-1:0]   locked, err_flag;
  logic [CW-1:0]    ok_cnt, err_cnt, first_err_idx;
  logic [NCH-1:0]   locked_s, err_flag_s;
  logic [NCH*4-1:0] ok_cnt_s, err_cnt_s, first_err_idx_s;

  adc_pattern_checker #(.NCH(NCH), .SPW(SPW), .SW(SW), .CNTW(CNTW)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .clr(clr), .mode(mode), .pattern(pattern),
    .din_valid(din_valid), .din(din), .locked(locked), .err_flag(err_flag),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  adc_pattern_checker #(.NCH(NCH), .SPW(SPW), .SW(SW), .CNTW(4)) dut_s (
    .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .clr(clr), .mode(mode), .pattern(pattern),
    .din_valid(din_valid), .din(din), .locked(locked_s), .err_flag(err_flag_s),
    .ok_cnt(ok_cnt_s), .err_cnt(err_cnt_s), .first_err_idx(first_err_idx_s)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct packed {
    int             due;
    logic [NCH-1:0] locked;
    logic [NCH-1:0] flag;
    logic [CW-1:0]  ok;
    logic [CW-1:0]  err;
    logic [CW-1:0]  first;
  } snap_t;

  snap_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one entry per channel.
  int            m_st[NCH];
  logic [SW-1:0] m_last[NCH];
  bit            m_phase[NCH];
  longint        m_ok[NCH], m_err[NCH], m_first[NCH];
  bit            m_flag[NCH];
  int            m_pend[NCH];
  logic [1:0]    m_mode_q;
  int            r[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = 0; m_last[c] = '0; m_phase[c] = 1'b0;
      m_ok[c] = 0; m_err[c] = 0; m_first[c] = 0; m_flag[c] = 1'b0; m_pend[c] = 0;
    end
    m_mode_q = 2'd0;
  endtask

  function automatic logic [CW-1:0] pack_cnt(input longint c0, input longint c1,
                                             input longint c2, input longint c3);
    logic [CW-1:0] v;
    v = '0;
    v[0*CNTW +: CNTW] = c0[CNTW-1:0];
    v[1*CNTW +: CNTW] = c1[CNTW-1:0];
    v[2*CNTW +: CNTW] = c2[CNTW-1:0];
    v[3*CNTW +: CNTW] = c3[CNTW-1:0];
    return v;
  endfunction

  task automatic model_drive(input bit v, input logic [WW-1:0] d, input bit c_clr);
    bit            relock, active, good;
    logic [SW-1:0] s[SPW];
    logic [SW-1:0] e;
    snap_t         sn;
    relock = c_clr || (mode != m_mode_q);
    active = en && (mode != 2'd3);
    sn = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c_clr) begin
        m_ok[c] = 0; m_err[c] = 0; m_first[c] = 0; m_flag[c] = 1'b0;
      end else if (m_pend[c] == 1) begin
        if (m_ok[c] < MAXC) m_ok[c]++;
      end else if (m_pend[c] == 2) begin
        if (!m_flag[c]) m_first[c] = m_ok[c] + m_err[c];
        m_flag[c] = 1'b1;
        if (m_err[c] < MAXC) m_err[c]++;
      end
      m_pend[c] = 0;
      for (int k = 0; k < SPW; k++) s[k] = d[c*SPW*SW + k*SW +: SW];
      if (!active) m_st[c] = 0;
      else if (m_st[c] == 0) m_st[c] = 1;
      else if (m_st[c] == 1 || relock) begin
        if (v) begin
          m_last[c] = s[SPW-1];
          m_phase[c] = (s[0] == pattern);
          m_st[c] = 2;
        end else m_st[c] = 1;
      end else if (v) begin
        good = 1'b1;
        for (int k = 0; k < SPW; k++) begin
          if (mode == 2'd0) begin
            if (k == 0) e = m_last[c] + 1'b1;
            else        e = s[k-1] + 1'b1;
          end else if (mode == 2'd1) e = pattern;
          else e = m_phase[c] ? ~pattern : pattern;
          if (s[k] != e) good = 1'b0;
        end
        m_pend[c] = good ? 1 : 2;
        m_last[c] = s[SPW-1];
        m_phase[c] = !m_phase[c];
      end
      sn.locked[c] = (m_st[c] == 2);
      sn.flag[c]   = m_flag[c];
    end
    m_mode_q = mode;
    sn.due   = edges + 1;
    sn.ok    = pack_cnt(m_ok[0], m_ok[1], m_ok[2], m_ok[3]);
    sn.err   = pack_cnt(m_err[0], m_err[1], m_err[2], m_err[3]);
    sn.first = pack_cnt(m_first[0], m_first[1], m_first[2], m_first[3]);
    sb_q.push_back(sn);
  endtask

  task automatic sb_compare();
    snap_t sn;
    while (sb_q.size() > 0 && sb_q[0].due <= edges) begin
      sn = sb_q.pop_front();
      if (sn.due < edges) check("sb_late", CW'(edges), CW'(sn.due));
      else begin
        check("sb_locked", CW'(locked), CW'(sn.locked));
        check("sb_flag", CW'(err_flag), CW'(sn.flag));
        check("sb_ok", ok_cnt, sn.ok);
        check("sb_err", err_cnt, sn.err);
        check("sb_first", first_err_idx, sn.first);
      end
    end
  endtask

  // Called at a negedge: drive one cycle, update the model, then compare what is due.
  task automatic step(input bit v, input logic [WW-1:0] d, input bit c_clr);
    din_valid = v;
    din       = d;
    clr       = c_clr;
    model_drive(v, d, c_clr);
    @(negedge clk);
    sb_compare();
  endtask

  task automatic idle(input bit c_clr);
    logic [WW-1:0] junk;
    junk = '0;
    for (int i = 0; i < WW / 32; i++) junk[i*32 +: 32] = $urandom();
    step(1'b0, junk, c_clr);
  endtask

  function automatic logic [WW-1:0] ramp_word(input int cc, input int ck, input logic [SW-1:0] xm);
    logic [WW-1:0] w;
    logic [SW-1:0] s;
    w = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < SPW; k++) begin
        s = SW'(r[c] + k);
        if (c == cc && k == ck) s = s ^ xm;
        w[c*SPW*SW + k*SW +: SW] = s;
      end
    return w;
  endfunction

  task automatic send_ramp(input int cc, input int ck, input logic [SW-1:0] xm, input bit c_clr);
    step(1'b1, ramp_word(cc, ck, xm), c_clr);
    for (int c = 0; c < NCH; c++) r[c] = (r[c] + SPW) % (1 << SW);
  endtask

  function automatic logic [WW-1:0] const_word(input logic [SW-1:0] val, input int ck,
                                               input logic [SW-1:0] alt);
    logic [WW-1:0] w;
    w = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < SPW; k++)
        w[c*SPW*SW + k*SW +: SW] = (k == ck) ? alt : val;
    return w;
  endfunction

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    check({tag, "_locked"}, CW'(locked), '0);
    check({tag, "_flag"}, CW'(err_flag), '0);
    check({tag, "_ok"}, ok_cnt, '0);
    check({tag, "_err"}, err_cnt, '0);
    check({tag, "_first"}, first_err_idx, '0);
    check({tag, "_ok_s"}, CW'(ok_cnt_s), '0);
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    for (int c = 0; c < NCH; c++) r[c] = c * 100;
    @(negedge clk);
    do_reset("rst0");

    // 1: continuous ramp
    en = 1'b1; mode = 2'd0;
    idle(1'b0);
    for (int i = 0; i < 1000; i++) send_ramp(-1, 0, '0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("t1_ok", ok_cnt, pack_cnt(999, 999, 999, 999));
    check("t1_err", err_cnt, '0);
    check("t1_flag", CW'(err_flag), '0);
    check("t1_locked", CW'(locked), CW'(4'hF));

    // 2: interior and last-sample corruption
    idle(1'b1);
    for (int i = 0; i < 70; i++) begin
      if (i == 50)      send_ramp(2, 3, 10'h001, 1'b0);
      else if (i == 60) send_ramp(1, 7, 10'h001, 1'b0);
      else              send_ramp(-1, 0, '0, 1'b0);
    end
    idle(1'b0); idle(1'b0);
    check("t2_err", err_cnt, pack_cnt(0, 2, 1, 0));
    check("t2_ok", ok_cnt, pack_cnt(69, 67, 68, 69));
    check("t2_first", first_err_idx, pack_cnt(0, 59, 49, 0));
    check("t2_flag", CW'(err_flag), CW'(4'b0110));

    // 3: fixed then toggle
    mode = 2'd1; pattern = 10'h2AA;
    idle(1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, const_word(10'h2AA, (i == 4) ? 5 : -1, 10'h2AB), 1'b0);
    idle(1'b0); idle(1'b0);
    check("t3_fixed_ok", ok_cnt, pack_cnt(8, 8, 8, 8));
    check("t3_fixed_err", err_cnt, pack_cnt(1, 1, 1, 1));
    mode = 2'd2;
    idle(1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, const_word((i % 2 == 0) ? 10'h2AA : 10'h155, -1, '0), 1'b0);
    idle(1'b0); idle(1'b0);
    check("t3_tgl_ok", ok_cnt, pack_cnt(27, 27, 27, 27));
    check("t3_tgl_err", err_cnt, pack_cnt(1, 1, 1, 1));

    // 4: ramp with gapped din_valid
    mode = 2'd0;
    idle(1'b1);
    nv = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_ramp(-1, 0, '0, 1'b0);
        nv++;
      end else idle(1'b0);
    end
    idle(1'b0); idle(1'b0);
    check("t4_ok", ok_cnt, pack_cnt(nv - 1, nv - 1, nv - 1, nv - 1));
    check("t4_err", err_cnt, '0);

    // 5: saturation on the narrow build, clr coinciding with a word
    idle(1'b1);
    for (int i = 0; i < 41; i++) send_ramp(-1, 0, '0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("t5_sat_ok_s", CW'(ok_cnt_s), CW'(16'hFFFF));
    check("t5_sat_err_s", CW'(err_cnt_s), '0);
    check("t5_ok", ok_cnt, pack_cnt(40, 40, 40, 40));
    send_ramp(-1, 0, '0, 1'b1);
    idle(1'b0); idle(1'b0);
    check("t5_clr_ok", ok_cnt, '0);
    check("t5_clr_ok_s", CW'(ok_cnt_s), '0);
    send_ramp(-1, 0, '0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("t5_next_ok", ok_cnt, pack_cnt(1, 1, 1, 1));
    check("t5_next_ok_s", CW'(ok_cnt_s), CW'(16'h1111));

    // 6: reset mid-stream, en low, reserved mode
    for (int i = 0; i < 20; i++) send_ramp(-1, 0, '0, 1'b0);
    do_reset("rst1");
    idle(1'b0);
    for (int i = 0; i < 30; i++) send_ramp(-1, 0, '0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) send_ramp(-1, 0, '0, 1'b0);
    check("t6_hold_ok", ok_cnt, pack_cnt(29, 29, 29, 29));
    check("t6_hold_locked", CW'(locked), '0);
    en = 1'b1; mode = 2'd3;
    for (int i = 0; i < 3; i++) send_ramp(-1, 0, '0, 1'b0);
    mode = 2'd0;
    idle(1'b0);
    for (int i = 0; i < 20; i++) send_ramp(-1, 0, '0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("t6_relock_ok", ok_cnt, pack_cnt(48, 48, 48, 48));
    check("t6_relock_err", err_cnt, '0);
    check("t6_relock_locked", CW'(locked), CW'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
